// File: rtl/core_pkg.sv
// Shared constants and types for the core architectural-state block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package core_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0] reg_idx_t;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  // Bank encoding used by every *_fmode signal
  localparam logic BANK_INT = 1'b0;
  localparam logic BANK_FLT = 1'b1;

endpackage

// File: rtl/regfile_bank.sv
// One register bank (storage + pending-write busy vector) with NRD async read ports.
// Latency: reads combinational from registered state; writes/busy updates land at the edge.
// Backpressure: none; never stalls, consumer gates issue with rd_busy.
module regfile_bank #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wr_en,
  input  logic [$clog2(NREG)-1:0]       wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          sb_set,
  input  logic [$clog2(NREG)-1:0]       sb_addr,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] regs_d, regs_q;
  logic [NREG-1:0]           busy_d, busy_q;

  // Next-state for storage and scoreboard; a set from a newer instruction
  // overrides a same-cycle clear from writeback.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    if (sb_set) begin
      busy_d[sb_addr] = 1'b1;
    end
    // Hard-wired zero register: entry 0 stays 0 and never busy, so the
    // read path below needs no special case.
    if (ZERO_R0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Asynchronous read ports from registered state only
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
      rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/core_regstate_unit.sv
// Core architectural state: PC, int/float register banks with scoreboard, instret counter.
// Latency: reads zero-cycle; writes visible next cycle (same cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: none; never stalls, consumer uses rd_busy to hold issue and pc_en.
module core_regstate_unit #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              NREG     = core_pkg::NREG,
  parameter int              NRD      = 2,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter int              CNT_W    = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pc_en,
  input  logic [XLEN-1:0]               next_pc,
  output logic [XLEN-1:0]               pc,
  input  logic [NRD-1:0]                rd_fmode,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic                          wr_en,
  input  logic                          wr_fmode,
  input  logic [$clog2(NREG)-1:0]       wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          sb_set,
  input  logic                          sb_fmode,
  input  logic [$clog2(NREG)-1:0]       sb_addr,
  output logic [CNT_W-1:0]              instret
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]  pc_d, pc_q;
  logic [CNT_W-1:0] instret_d, instret_q;

  logic             int_wr_en, flt_wr_en;
  logic             int_sb_set, flt_sb_set;
  logic [NRD*XLEN-1:0] int_rd_data, flt_rd_data;
  logic [NRD-1:0]      int_rd_busy, flt_rd_busy;

  // PC and retired-instruction counter advance together on pc_en
  always_comb begin
    pc_d      = pc_q;
    instret_d = instret_q;
    if (pc_en) begin
      pc_d      = next_pc;
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // PC / instret registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  assign pc      = pc_q;
  assign instret = instret_q;

  // Steer write and scoreboard strobes to the selected bank
  always_comb begin
    int_wr_en  = wr_en  && (wr_fmode == core_pkg::BANK_INT);
    flt_wr_en  = wr_en  && (wr_fmode == core_pkg::BANK_FLT);
    int_sb_set = sb_set && (sb_fmode == core_pkg::BANK_INT);
    flt_sb_set = sb_set && (sb_fmode == core_pkg::BANK_FLT);
  end

  regfile_bank #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .NRD     (NRD),
    .ZERO_R0 (1'b1)
  ) u_int_bank (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (int_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sb_set  (int_sb_set),
    .sb_addr (sb_addr),
    .rd_addr (rd_addr),
    .rd_data (int_rd_data),
    .rd_busy (int_rd_busy)
  );

  regfile_bank #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .NRD     (NRD),
    .ZERO_R0 (1'b0)
  ) u_flt_bank (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (flt_wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sb_set  (flt_sb_set),
    .sb_addr (sb_addr),
    .rd_addr (rd_addr),
    .rd_data (flt_rd_data),
    .rd_busy (flt_rd_busy)
  );

  // Per-port bank select, with optional same-cycle writeback forwarding
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_fmode[i] == core_pkg::BANK_FLT) begin
        rd_data[i*XLEN +: XLEN] = flt_rd_data[i*XLEN +: XLEN];
        rd_busy[i]              = flt_rd_busy[i];
      end else begin
        rd_data[i*XLEN +: XLEN] = int_rd_data[i*XLEN +: XLEN];
        rd_busy[i]              = int_rd_busy[i];
      end
`ifdef REGFILE_BYPASS_EN
      // The in-flight write resolves the pending value, so the port is not busy
      if (wr_en && (wr_fmode == rd_fmode[i]) && (wr_addr == rd_addr[i*AW +: AW])) begin
        if ((rd_fmode[i] == core_pkg::BANK_INT) && (rd_addr[i*AW +: AW] == '0)) begin
          rd_data[i*XLEN +: XLEN] = '0;
        end else begin
          rd_data[i*XLEN +: XLEN] = wr_data;
        end
        rd_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule
